// File: rtl/mem_responder_pkg.sv
// Shared definitions for the main-memory responder: FSM states,
// write-back source indices and default widths.
package mem_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Write-back source indices; a higher index wins on address collision.
  localparam int WB_CPU0 = 0;
  localparam int WB_BUS0 = 1;
  localparam int WB_CPU1 = 2;
  localparam int WB_BUS1 = 3;

  localparam int NUM_WB    = 4;
  localparam int NUM_CACHE = 2;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LAT    = 3;

endpackage

// File: rtl/wb_bypass_mux.sv
// Priority match of one address against the four write-back ports.
// The highest-indexed enabled port with a matching address supplies data.
module wb_bypass_mux
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [NUM_WB*ADDR_W-1:0] wb_addr,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Scan in ascending order so later (higher-index) matches override.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_en[k] && (wb_addr[k*ADDR_W +: ADDR_W] == addr)) begin
        hit  = 1'b1;
        data = wb_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Shared main-memory responder: round-robin read service for two caches
// with fixed latency, snoop abort, and four always-on write-back ports.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT    = DEF_LAT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CACHE-1:0]        rd_req,
  input  logic [NUM_CACHE*ADDR_W-1:0] rd_addr,
  input  logic [NUM_CACHE-1:0]        abort,
  input  logic [NUM_WB-1:0]           wb_en,
  input  logic [NUM_WB*ADDR_W-1:0]    wb_addr,
  input  logic [NUM_WB*DATA_W-1:0]    wb_data,
  output logic [NUM_CACHE-1:0]        rd_valid,
  output logic [NUM_CACHE*DATA_W-1:0] rd_data,
  output logic                        busy,
  output logic                        grant_id
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t                        state_q, state_d;
  logic                          g_q, g_d;
  logic                          rr_q, rr_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [NUM_CACHE-1:0]          vld_q, vld_d;
  logic [NUM_CACHE*DATA_W-1:0]   data_q, data_d;
  logic [NUM_CACHE-1:0]          elig;

  logic [DATA_W-1:0]             mem [DEPTH];

  logic                          rb_hit;
  logic [DATA_W-1:0]             rb_data;
  logic [DATA_W-1:0]             rd_word;
  logic [NUM_WB-1:0]             wr_hit;
  logic [DATA_W-1:0]             wr_data [NUM_WB];

  // Read bypass: a write-back landing on the latched address this cycle
  // is returned instead of the stale array word.
  wb_bypass_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_bypass (
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .addr    (addr_q),
    .hit     (rb_hit),
    .data    (rb_data)
  );

  // Collision resolution: each port writes the winning data for its own
  // address, so colliding ports all store the highest-index value.
  for (genvar k = 0; k < NUM_WB; k++) begin : g_wr_res
    wb_bypass_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_res (
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .addr    (wb_addr[k*ADDR_W +: ADDR_W]),
      .hit     (wr_hit[k]),
      .data    (wr_data[k])
    );
  end

  assign rd_word = rb_hit ? rb_data : mem[addr_q];
  assign elig    = rd_req & ~abort & ~vld_q;

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_en[k] && wr_hit[k]) begin
        mem[wb_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k];
      end
    end
  end

  // Next-state, arbitration, countdown and response formation.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    vld_d   = '0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (elig != '0) begin
          g_d     = (elig == 2'b11) ? rr_q : elig[1];
          addr_d  = g_d ? rd_addr[ADDR_W +: ADDR_W] : rd_addr[0 +: ADDR_W];
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort[g_q]) begin
          rr_d    = ~g_q;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          vld_d[g_q] = 1'b1;
          if (g_q) begin
            data_d[DATA_W +: DATA_W] = rd_word;
          end else begin
            data_d[0 +: DATA_W] = rd_word;
          end
          rr_d    = ~g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      vld_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  // Latched request address; only meaningful while in WAIT.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign rd_valid = vld_q;
  assign rd_data  = data_q;
  assign busy     = (state_q == WAIT);
  assign grant_id = g_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_W=4, DATA_W=32, LAT=3).
module tb_mem_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   rd_req;
  logic [7:0]   rd_addr;
  logic [1:0]   abort;
  logic [3:0]   wb_en;
  logic [15:0]  wb_addr;
  logic [127:0] wb_data;
  logic [1:0]   rd_valid;
  logic [63:0]  rd_data;
  logic         busy;
  logic         grant_id;

  int checks   = 0;
  int failures = 0;

  mem_responder #(.ADDR_W(4), .DATA_W(32), .LAT(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .abort    (abort),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; rd_req = '0; rd_addr = '0; abort = '0;
    wb_en = '0; wb_addr = '0; wb_data = '0;
    #1;
    ticks(2);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data",  rd_data,       64'd0);
    chk("rst_busy",  64'(busy),     64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    reset = 1'b0;

    // Preload mem[5], mem[2], mem[7], mem[9] through the four ports.
    wb_en   = 4'b1111;
    wb_addr = {4'd9, 4'd7, 4'd2, 4'd5};
    wb_data = {32'h0000_0900, 32'h0000_0700, 32'h0000_0200, 32'hA5A5_0001};
    tick();
    wb_en = '0;

    // Single read, cache0 addr 5: busy cycles 1-3, valid at cycle 4 only.
    rd_req = 2'b01; rd_addr = {4'd0, 4'd5};
    tick();
    chk("t1_busy_c1",  64'(busy),     64'd1);
    chk("t1_valid_c1", 64'(rd_valid), 64'd0);
    ticks(2);
    chk("t1_busy_c3",  64'(busy),     64'd1);
    chk("t1_valid_c3", 64'(rd_valid), 64'd0);
    tick();
    chk("t1_valid_c4", 64'(rd_valid), 64'b01);
    chk("t1_data_c4",  64'(rd_data[31:0]), 64'hA5A5_0001);
    chk("t1_busy_c4",  64'(busy),     64'd0);
    rd_req = 2'b00;
    tick();
    chk("t1_valid_c5", 64'(rd_valid), 64'd0);

    // Both request after a cache0 grant: rr points at cache1.
    rd_req = 2'b11; rd_addr = {4'd7, 4'd2};
    tick();
    chk("rr_grant_c1", 64'(grant_id), 64'd1);
    ticks(3);
    chk("rr_valid_c4", 64'(rd_valid), 64'b10);
    chk("rr_data1_c4", 64'(rd_data[63:32]), 64'h700);
    rd_req = 2'b01;
    tick();
    chk("rr_grant_c5", 64'(grant_id), 64'd0);
    chk("rr_busy_c5",  64'(busy),     64'd1);
    ticks(3);
    chk("rr_valid_c8", 64'(rd_valid), 64'b01);
    chk("rr_data0_c8", 64'(rd_data[31:0]),  64'h200);
    chk("rr_hold1_c8", 64'(rd_data[63:32]), 64'h700);
    rd_req = 2'b00;
    tick();

    // After reset rr=0: both request, cache0 first at 4, cache1 at 8.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_data",  rd_data,       64'd0);
    chk("rst2_grant", 64'(grant_id), 64'd0);
    rd_req = 2'b11; rd_addr = {4'd7, 4'd2};
    ticks(4);
    chk("b2b_valid_c4", 64'(rd_valid), 64'b01);
    chk("b2b_data0_c4", 64'(rd_data[31:0]), 64'h200);
    rd_req = 2'b10;
    ticks(3);
    chk("b2b_valid_c7", 64'(rd_valid), 64'd0);
    tick();
    chk("b2b_valid_c8", 64'(rd_valid), 64'b10);
    chk("b2b_data1_c8", 64'(rd_data[63:32]), 64'h700);
    rd_req = 2'b00;
    tick();

    // Abort of cache1 in cycle 2; pending cache0 granted in cycle 3.
    rd_req = 2'b10; rd_addr = {4'd7, 4'd0};
    tick();
    chk("ab_grant_c1", 64'(grant_id), 64'd1);
    rd_req = 2'b11; rd_addr = {4'd7, 4'd5};
    tick();
    abort = 2'b10; rd_req = 2'b01;
    tick();
    chk("ab_busy_c3",  64'(busy),     64'd0);
    chk("ab_valid_c3", 64'(rd_valid), 64'd0);
    abort = 2'b00;
    tick();
    chk("ab_busy_c4",  64'(busy),     64'd1);
    chk("ab_grant_c4", 64'(grant_id), 64'd0);
    ticks(2);
    chk("ab_valid_c6", 64'(rd_valid), 64'd0);
    tick();
    chk("ab_valid_c7", 64'(rd_valid), 64'b01);
    chk("ab_data_c7",  64'(rd_data[31:0]), 64'hA5A5_0001);
    rd_req = 2'b00;
    tick();

    // Abort in the completion cycle wins over completion.
    rd_req = 2'b10; rd_addr = {4'd7, 4'd0};
    ticks(3);
    abort = 2'b10;
    tick();
    chk("abc_valid_c4", 64'(rd_valid), 64'd0);
    chk("abc_busy_c4",  64'(busy),     64'd0);
    abort = 2'b00; rd_req = 2'b00;
    tick();

    // Write-backs to addr 9 from cpu0 and cpu1 in the completion cycle.
    rd_req = 2'b01; rd_addr = {4'd0, 4'd9};
    ticks(3);
    wb_en   = 4'b0101;
    wb_addr = {4'd0, 4'd9, 4'd0, 4'd9};
    wb_data = {32'h0, 32'h22, 32'h0, 32'h11};
    tick();
    chk("byp_valid_c4", 64'(rd_valid), 64'b01);
    chk("byp_data_c4",  64'(rd_data[31:0]), 64'h22);
    wb_en = '0;
    rd_req = 2'b10; rd_addr = {4'd9, 4'd0};
    ticks(4);
    chk("byp_mem_valid", 64'(rd_valid), 64'b10);
    chk("byp_mem_data",  64'(rd_data[63:32]), 64'h22);
    rd_req = 2'b00;
    tick();

    // Four-way collision at addr 3: bus1 (data 4) wins.
    wb_en   = 4'b1111;
    wb_addr = {4'd3, 4'd3, 4'd3, 4'd3};
    wb_data = {32'd4, 32'd3, 32'd2, 32'd1};
    tick();
    wb_en = '0;
    rd_req = 2'b01; rd_addr = {4'd0, 4'd3};
    ticks(4);
    chk("col_valid", 64'(rd_valid), 64'b01);
    chk("col_data",  64'(rd_data[31:0]), 64'd4);
    rd_req = 2'b00;
    tick();

    // Reset in cycle 2 of a cache1 WAIT drops the transaction.
    rd_req = 2'b10; rd_addr = {4'd5, 4'd0};
    tick();
    chk("rmid_grant_c1", 64'(grant_id), 64'd1);
    tick();
    reset = 1'b1; rd_req = 2'b00;
    tick();
    chk("rmid_valid", 64'(rd_valid), 64'd0);
    chk("rmid_busy",  64'(busy),     64'd0);
    chk("rmid_grant", 64'(grant_id), 64'd0);
    chk("rmid_data",  rd_data,       64'd0);
    reset = 1'b0;
    ticks(3);
    chk("rmid_valid_late", 64'(rd_valid), 64'd0);

    // Memory written before reset is retained.
    rd_req = 2'b01; rd_addr = {4'd0, 4'd9};
    ticks(4);
    chk("ret9_valid", 64'(rd_valid), 64'b01);
    chk("ret9_data",  64'(rd_data[31:0]), 64'h22);
    rd_req = 2'b00;
    tick();
    rd_req = 2'b10; rd_addr = {4'd3, 4'd0};
    ticks(4);
    chk("ret3_valid", 64'(rd_valid), 64'b10);
    chk("ret3_data",  64'(rd_data[63:32]), 64'd4);
    rd_req = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
